// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner selection for an N:1 shared multiplexor.
// One requester owns the mux at a time. Ownership ends when the owner
// raises done, or when it has held the grant for MAX_HOLD cycles. In the
// timeout case a one-cycle timeout pulse follows. Every output comes
// straight from a flop, so req and done never reach an output
// combinationally.
// The parameters must satisfy 2**AW >= N so every index fits in addr.

module mux_arbiter #(
  parameter int N        = 20,
  parameter int AW       = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [AW-1:0] addr,
  output logic [N-1:0]  grant,
  output logic          valid,
  output logic          timeout
);

  // Hold counter width. The counter counts 0 .. MAX_HOLD-1.
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  // After reset, last points at the top index so the first search starts at 0.
  localparam logic [AW-1:0] LAST_RST  = AW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic          found;
    logic [AW-1:0] idx;
  } pick_t;

  // Returns the first set bit of r, searching from last+1 upward and
  // wrapping from N-1 to 0. Each candidate position is computed with
  // AW-bit arithmetic, so no intermediate value can exceed N-1.
  // The loop runs from the farthest candidate to the nearest, so the
  // nearest set bit is the one left in p when the loop ends.
  function automatic pick_t rr_pick(input logic [N-1:0] r, input logic [AW-1:0] last);
    pick_t         p;
    logic [AW-1:0] pos;
    p.found = 1'b0;
    p.idx   = {AW{1'b0}};
    for (int j = N - 1; j >= 0; j--) begin
      if (last >= AW'(N - 1 - j)) begin
        pos = last - AW'(N - 1 - j);
      end else begin
        pos = last + AW'(j + 1);
      end
      if (r[pos]) begin
        p.found = 1'b1;
        p.idx   = pos;
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Decodes an owner index into the one-hot grant vector.
  function automatic logic [N-1:0] to_onehot(input logic [AW-1:0] idx);
    logic [N-1:0] g;
    for (int j = 0; j < N; j++) begin
      g[j] = (idx == AW'(j));
    end
    return g;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_s;
  logic [N-1:0]  grant_r;
  logic [N-1:0]  grant_s;
  logic          valid_r;
  logic          valid_s;
  logic          timeout_r;
  logic          timeout_s;
  logic [CW-1:0] hold_r;
  logic [CW-1:0] hold_s;
  logic [AW-1:0] last_r;
  logic [AW-1:0] last_s;

  pick_t         idle_pick_s;
  pick_t         busy_pick_s;
  logic          expire_s;

  // In BUSY, last_r equals the current owner. Masking the owner's own
  // request makes a releasing owner unable to win its own re-grant.
  assign idle_pick_s = rr_pick(req, last_r);
  assign busy_pick_s = rr_pick(req & ~grant_r, last_r);

  // Forced release: the counter has reached its final value and the
  // owner did not release in the same cycle. A done in that cycle wins.
  assign expire_s    = (hold_r == HOLD_LAST) & ~done;

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    grant_s   = grant_r;
    valid_s   = valid_r;
    timeout_s = 1'b0;
    hold_s    = hold_r;
    last_s    = last_r;
    case (state_r)
      IDLE: begin
        if (idle_pick_s.found) begin
          state_s = BUSY;
          addr_s  = idle_pick_s.idx;
          grant_s = to_onehot(idle_pick_s.idx);
          valid_s = 1'b1;
          last_s  = idle_pick_s.idx;
          hold_s  = {CW{1'b0}};
        end else begin
          // addr keeps its previous value while nobody owns the mux.
          state_s = IDLE;
          grant_s = {N{1'b0}};
          valid_s = 1'b0;
          hold_s  = {CW{1'b0}};
        end
      end
      BUSY: begin
        if (done || expire_s) begin
          timeout_s = expire_s;
          if (busy_pick_s.found) begin
            // Back-to-back handover: valid stays high.
            state_s = BUSY;
            addr_s  = busy_pick_s.idx;
            grant_s = to_onehot(busy_pick_s.idx);
            valid_s = 1'b1;
            last_s  = busy_pick_s.idx;
            hold_s  = {CW{1'b0}};
          end else begin
            state_s = IDLE;
            grant_s = {N{1'b0}};
            valid_s = 1'b0;
            hold_s  = {CW{1'b0}};
          end
        end else begin
          // Owner keeps the grant; count the cycle, saturating at the top.
          if (hold_r == HOLD_LAST) begin
            hold_s = hold_r;
          end else begin
            hold_s = hold_r + CW'(1);
          end
        end
      end
      default: begin
        state_s   = IDLE;
        addr_s    = {AW{1'b0}};
        grant_s   = {N{1'b0}};
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        hold_s    = {CW{1'b0}};
        last_s    = LAST_RST;
      end
    endcase
  end

  // State and output registers. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= {AW{1'b0}};
      grant_r   <= {N{1'b0}};
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      hold_r    <= {CW{1'b0}};
      last_r    <= LAST_RST;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      grant_r   <= grant_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
      hold_r    <= hold_s;
      last_r    <= last_s;
    end
  end

  assign addr    = addr_r;
  assign grant   = grant_r;
  assign valid   = valid_r;
  assign timeout = timeout_r;

endmodule
